// File: rtl/tone_scheduler_if.sv
// tone_scheduler_if: command, table-load and Beeper-side signals of the tone scheduler
// master: drives cmd_valid/cmd_data, wr_en/wr_addr/wr_note/wr_dur, song_len; samples tone/tone_en/busy/note_idx/done
// slave : the scheduler, the mirror image of master
interface tone_scheduler_if #(
  parameter int DEPTH_W = 7,
  parameter int DUR_W   = 16
);
  logic               cmd_valid;
  logic [7:0]         cmd_data;
  logic               wr_en;
  logic [DEPTH_W-1:0] wr_addr;
  logic [4:0]         wr_note;
  logic [DUR_W-1:0]   wr_dur;
  logic [DEPTH_W:0]   song_len;
  logic [4:0]         tone;
  logic               tone_en;
  logic               busy;
  logic [DEPTH_W-1:0] note_idx;
  logic               done;
  modport master (
    output cmd_valid, cmd_data, wr_en, wr_addr, wr_note, wr_dur, song_len,
    input  tone, tone_en, busy, note_idx, done
  );
  modport slave (
    input  cmd_valid, cmd_data, wr_en, wr_addr, wr_note, wr_dur, song_len,
    output tone, tone_en, busy, note_idx, done
  );
endinterface

// File: rtl/tone_scheduler.sv
// tone_scheduler: song-table playback and live-note controller driving the Beeper tone input
// i_sys_clk   : system clock
// i_sys_rst_n : synchronous active-low reset
// bus (slave) : command byte strobe, table write port, song_len in; tone/tone_en/busy/note_idx/done out
module tone_scheduler #(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 1000,
  parameter int DEPTH_W  = 7,
  parameter int DUR_W    = 16
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst_n,
  tone_scheduler_if.slave  bus
);
  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [DEPTH_W:0] MAXLEN = {1'b1, {DEPTH_W{1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_PAUSE} state_t;
  state_t             r_state, w_state;
  logic [4:0]         r_tone, w_tone;
  logic               r_en, w_en, r_done, w_done, r_loop, w_loop, w_adv;
  logic [DEPTH_W-1:0] r_idx, w_idx;
  logic [DEPTH_W:0]   r_len, w_len;
  logic [PW-1:0]      r_pre, w_pre;
  logic [DUR_W-1:0]   r_dur, w_dur;
  logic [4+DUR_W:0]   r_mem [2**DEPTH_W];
  logic [4:0]         w_note;
  logic [DUR_W-1:0]   w_edur;
  // Read is sampled at the FETCH exit edge, so a same-cycle write to that entry lands after the read.
  assign {w_note, w_edur} = r_mem[r_idx];
  wire w_live   = bus.cmd_valid && bus.cmd_data[7:5] == 3'd0;
  wire w_play   = bus.cmd_valid && bus.cmd_data == 8'h80 && bus.song_len != '0;
  wire w_stop   = bus.cmd_valid && bus.cmd_data == 8'h81;
  wire w_pause  = bus.cmd_valid && bus.cmd_data == 8'h82;
  wire w_resume = bus.cmd_valid && bus.cmd_data == 8'h83;
  wire w_tgl    = bus.cmd_valid && bus.cmd_data == 8'h84;
  wire w_tick   = r_pre == PW'(DIV - 1);
  wire w_last   = {1'b0, r_idx} >= r_len - 1'b1;
  always_comb begin
    w_state = r_state;
    w_tone  = r_tone;
    w_en    = r_en;
    w_done  = 1'b0;
    w_loop  = r_loop ^ w_tgl;
    w_idx   = r_idx;
    w_len   = r_len;
    w_pre   = r_pre;
    w_dur   = r_dur;
    w_adv   = 1'b0;
    if (w_stop) begin
      w_state = S_IDLE;
      w_tone  = 5'd0;
      w_en    = 1'b0;
    end else if (w_play) begin
      w_state = S_FETCH;
      w_idx   = '0;
      w_len   = bus.song_len > MAXLEN ? MAXLEN : bus.song_len;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tone = w_live ? bus.cmd_data[4:0] : r_tone;
          w_en   = w_live ? |bus.cmd_data[4:0] : r_en;
        end
        S_FETCH: begin
          w_tone  = w_note;
          w_en    = |w_note;
          w_dur   = w_edur;
          w_pre   = '0;
          w_state = S_PLAY;
          w_adv   = w_edur == '0;
        end
        S_PLAY: begin
          if (w_pause) begin
            w_state = S_PAUSE;
            w_en    = 1'b0;
          end else begin
            w_pre = w_tick ? '0 : r_pre + 1'b1;
            w_dur = w_tick ? r_dur - 1'b1 : r_dur;
            w_adv = w_tick && r_dur == DUR_W'(1);
          end
        end
        default: begin
          w_state = w_resume ? S_PLAY : S_PAUSE;
          w_en    = w_resume ? |r_tone : 1'b0;
        end
      endcase
    end
    if (w_adv) begin
      if (!w_last || r_loop) begin
        w_idx   = w_last ? '0 : r_idx + 1'b1;
        w_state = S_FETCH;
      end else begin
        w_state = S_IDLE;
        w_tone  = 5'd0;
        w_en    = 1'b0;
        w_done  = 1'b1;
      end
    end
  end
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      r_state <= S_IDLE;
      r_tone  <= 5'd0;
      r_en    <= 1'b0;
      r_done  <= 1'b0;
      r_loop  <= 1'b0;
      r_idx   <= '0;
      r_len   <= '0;
      r_pre   <= '0;
      r_dur   <= '0;
    end else begin
      r_state <= w_state;
      r_tone  <= w_tone;
      r_en    <= w_en;
      r_done  <= w_done;
      r_loop  <= w_loop;
      r_idx   <= w_idx;
      r_len   <= w_len;
      r_pre   <= w_pre;
      r_dur   <= w_dur;
    end
  end
  always_ff @(posedge i_sys_clk) begin
    if (bus.wr_en) r_mem[bus.wr_addr] <= {bus.wr_note, bus.wr_dur};
  end
  assign bus.tone     = r_tone;
  assign bus.tone_en  = r_en;
  assign bus.busy     = r_state != S_IDLE;
  assign bus.note_idx = r_idx;
  assign bus.done     = r_done;
endmodule
